// File: rtl/stb_ack_mult_pkg.sv
// Shared state encoding and default geometry for the strobe/ack fixed-point multiplier.
package stb_ack_mult_pkg;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_FRAC  = 8;

    typedef enum logic [2:0] {
        GET_A = 3'd0,
        GET_B = 3'd1,
        MULT  = 3'd2,
        NORM  = 3'd3,
        PUT_Z = 3'd4
    } state_t;

endpackage

// File: rtl/stb_ack_fixed_multiplier_shift_add_core.sv
// Unsigned radix-2 shift-add multiplier: one multiplier bit per cycle, WIDTH cycles,
// one-cycle o_done pulse after the last step.
module shift_add_core #(
    parameter int WIDTH = 16
) (
    input  logic                 in_clk,
    input  logic                 in_reset,
    input  logic                 i_start,
    input  logic [WIDTH-1:0]     i_mcand,
    input  logic [WIDTH-1:0]     i_mplier,
    output logic                 o_busy,
    output logic                 o_done,
    output logic [2*WIDTH-1:0]   o_product
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [2*WIDTH-1:0] r_mcand;
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_mplier;
    logic [CW-1:0]      r_cnt;
    logic               r_busy;
    logic               r_done;

    always_ff @(posedge in_clk or negedge in_reset) begin
        if (!in_reset) begin
            r_mcand  <= '0;
            r_acc    <= '0;
            r_mplier <= '0;
            r_cnt    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (i_start) begin
                r_mcand  <= {{WIDTH{1'b0}}, i_mcand};
                r_mplier <= i_mplier;
                r_acc    <= '0;
                r_cnt    <= '0;
                r_busy   <= 1'b1;
            end else if (r_busy) begin
                if (r_mplier[0])
                    r_acc <= r_acc + r_mcand;
                r_mcand  <= r_mcand << 1;
                r_mplier <= r_mplier >> 1;
                r_cnt    <= r_cnt + CW'(1);
                // No early exit on zero operands: latency is always WIDTH steps.
                if (r_cnt == CW'(WIDTH - 1)) begin
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                end
            end
        end
    end

    assign o_busy    = r_busy;
    assign o_done    = r_done;
    assign o_product = r_acc;

endmodule

// File: rtl/stb_ack_fixed_multiplier.sv
// Signed Q(WIDTH-FRAC).FRAC multiplier with strobe/ack handshakes on A, B and Z.
// Define STB_ACK_MULT_SAT_EN to clamp overflowing results instead of wrapping.
module stb_ack_fixed_multiplier
    import stb_ack_mult_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int FRAC  = DEF_FRAC
) (
    input  logic             in_clk,
    input  logic             in_reset,
    input  logic [WIDTH-1:0] input_a,
    input  logic             input_a_stb,
    output logic             input_a_ack,
    input  logic [WIDTH-1:0] input_b,
    input  logic             input_b_stb,
    output logic             input_b_ack,
    output logic [WIDTH-1:0] output_z,
    output logic             output_z_stb,
    input  logic             output_z_ack
);

    state_t             r_state;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_z;
    logic               r_a_ack;
    logic               r_b_ack;
    logic               r_z_stb;

    logic [WIDTH-1:0]   w_mag_a;
    logic [WIDTH-1:0]   w_mag_b;
    logic               w_start;
    logic               w_busy;
    logic               w_done;
    logic [2*WIDTH-1:0] w_product;
    logic [2*WIDTH-1:0] w_shifted;
    logic [2*WIDTH-1:0] w_signed;
    logic               w_neg;
    logic [WIDTH-1:0]   w_result;
    logic               w_unused;

    // Magnitudes stay WIDTH-bit unsigned so the most negative value maps exactly.
    assign w_mag_a = r_a[WIDTH-1]     ? (~r_a + 1'b1)     : r_a;
    assign w_mag_b = input_b[WIDTH-1] ? (~input_b + 1'b1) : input_b;
    assign w_start = (r_state == GET_B) && r_b_ack && input_b_stb;

    shift_add_core #(.WIDTH(WIDTH)) u_core (
        .in_clk   (in_clk),
        .in_reset (in_reset),
        .i_start  (w_start),
        .i_mcand  (w_mag_a),
        .i_mplier (w_mag_b),
        .o_busy   (w_busy),
        .o_done   (w_done),
        .o_product(w_product)
    );

    // Shift the magnitude first so truncation is toward zero for both signs.
    assign w_shifted = w_product >> FRAC;
    assign w_neg     = r_a[WIDTH-1] ^ r_b[WIDTH-1];
    assign w_signed  = w_neg ? (~w_shifted + 1'b1) : w_shifted;

`ifdef STB_ACK_MULT_SAT_EN
    localparam logic [2*WIDTH-1:0] POS_LIM = {{(WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic [2*WIDTH-1:0] NEG_LIM = {{WIDTH{1'b0}}, 1'b1, {(WIDTH-1){1'b0}}};

    always_comb begin
        w_result = w_signed[WIDTH-1:0];
        if (!w_neg && (w_shifted > POS_LIM))
            w_result = {1'b0, {(WIDTH-1){1'b1}}};
        else if (w_neg && (w_shifted > NEG_LIM))
            w_result = {1'b1, {(WIDTH-1){1'b0}}};
    end

    assign w_unused = w_busy;
`else
    assign w_result = w_signed[WIDTH-1:0];
    assign w_unused = ^{w_busy, w_signed[2*WIDTH-1:WIDTH]};
`endif

    always_ff @(posedge in_clk or negedge in_reset) begin
        if (!in_reset) begin
            r_state <= GET_A;
            r_a     <= '0;
            r_b     <= '0;
            r_z     <= '0;
            r_a_ack <= 1'b0;
            r_b_ack <= 1'b0;
            r_z_stb <= 1'b0;
        end else begin
            case (r_state)
                GET_A: begin
                    r_a_ack <= 1'b1;
                    if (r_a_ack && input_a_stb) begin
                        r_a     <= input_a;
                        r_a_ack <= 1'b0;
                        r_b_ack <= 1'b1;
                        r_state <= GET_B;
                    end
                end
                GET_B: begin
                    if (r_b_ack && input_b_stb) begin
                        r_b     <= input_b;
                        r_b_ack <= 1'b0;
                        r_state <= MULT;
                    end
                end
                MULT: begin
                    if (w_done)
                        r_state <= NORM;
                end
                NORM: begin
                    r_z     <= w_result;
                    r_z_stb <= 1'b1;
                    r_state <= PUT_Z;
                end
                PUT_Z: begin
                    if (output_z_ack) begin
                        r_z_stb <= 1'b0;
                        r_a_ack <= 1'b1;
                        r_state <= GET_A;
                    end
                end
                default: r_state <= GET_A;
            endcase
        end
    end

    assign input_a_ack  = r_a_ack;
    assign input_b_ack  = r_b_ack;
    assign output_z     = r_z;
    assign output_z_stb = r_z_stb;

endmodule

// File: tb/tb_stb_ack_fixed_multiplier.sv
// Randomised bench for stb_ack_fixed_multiplier against a signed-arithmetic reference model.
module tb_stb_ack_fixed_multiplier;

    localparam int W = 16;
    localparam int F = 8;

    logic         in_clk = 1'b0;
    logic         in_reset = 1'b0;
    logic [W-1:0] input_a = '0;
    logic [W-1:0] input_b = '0;
    logic         input_a_stb = 1'b0;
    logic         input_b_stb = 1'b0;
    logic         output_z_ack = 1'b0;
    logic         input_a_ack;
    logic         input_b_ack;
    logic [W-1:0] output_z;
    logic         output_z_stb;

    int checks = 0;
    int fails  = 0;
    int cyc    = 0;

    typedef struct {
        logic [W-1:0] z;
        int           at;
    } exp_t;
    exp_t expq[$];

    stb_ack_fixed_multiplier #(.WIDTH(W), .FRAC(F)) dut (
        .in_clk      (in_clk),
        .in_reset    (in_reset),
        .input_a     (input_a),
        .input_a_stb (input_a_stb),
        .input_a_ack (input_a_ack),
        .input_b     (input_b),
        .input_b_stb (input_b_stb),
        .input_b_ack (input_b_ack),
        .output_z    (output_z),
        .output_z_stb(output_z_stb),
        .output_z_ack(output_z_ack)
    );

    always #5 in_clk = ~in_clk;
    always @(posedge in_clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got time %0t required < 500000", $time);
        $fatal(1);
    end

    task automatic chk(input bit ok, input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (!ok) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Real-valued fixed-point product: signed multiply, divide (truncates toward zero).
    function automatic logic [W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
        longint p, q;
        p = longint'($signed(a)) * longint'($signed(b));
        q = p / (longint'(1) << F);
`ifdef STB_ACK_MULT_SAT_EN
        if (q > 32767)  q = 32767;
        if (q < -32768) q = -32768;
`endif
        return q[W-1:0];
    endfunction

    // Compare process: samples shortly after each rising edge.
    initial begin : cmp
        logic         p_stb;
        logic         ack_e;
        logic [W-1:0] p_z;
        exp_t         e;
        p_stb = 1'b0;
        p_z   = '0;
        forever begin
            @(posedge in_clk);
            ack_e = output_z_ack;
            #2;
            if (!in_reset) begin
                p_stb = 1'b0;
                p_z   = '0;
            end else begin
                chk($countones({input_a_ack, input_b_ack, output_z_stb}) <= 1, "onehot",
                    {29'b0, input_a_ack, input_b_ack, output_z_stb}, 32'd0);
                if (output_z_stb && !p_stb) begin
                    if (expq.size() == 0) begin
                        chk(1'b0, "unexpected_stb", 32'(output_z), 32'd0);
                    end else begin
                        e = expq.pop_front();
                        chk(output_z == e.z, "result", 32'(output_z), 32'(e.z));
                        chk(cyc == e.at, "latency_cycle", 32'(cyc), 32'(e.at));
                    end
                end else if (output_z_stb && p_stb) begin
                    chk(output_z == p_z, "z_stable", 32'(output_z), 32'(p_z));
                end
                if (p_stb && ack_e) begin
                    chk(!output_z_stb, "stb_drop_after_ack", 32'(output_z_stb), 32'd0);
                    chk(input_a_ack, "a_ack_after_ack", 32'(input_a_ack), 32'd1);
                    chk(output_z == p_z, "z_retained", 32'(output_z), 32'(p_z));
                end
                p_stb = output_z_stb;
                p_z   = output_z;
            end
        end
    end

    // Runs one transaction; starts and ends on a falling edge.
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input int hold,
                         input bit both, input bit noise, input bit abort);
        int t;
        input_a = a;
        input_a_stb = 1'b1;
        if (both) begin
            input_b = b;
            input_b_stb = 1'b1;
        end
        t = 0;
        while (!input_a_ack && t < 200) begin @(negedge in_clk); t++; end
        if (t >= 200) begin chk(1'b0, "a_ack_timeout", 32'(t), 32'd200); input_a_stb = 1'b0; return; end
        @(negedge in_clk);
        input_a_stb = 1'b0;
        if (both)
            chk(input_b_ack && !input_a_ack, "b_not_taken_with_a", {30'b0, input_a_ack, input_b_ack}, 32'd1);
        input_b = b;
        input_b_stb = 1'b1;
        t = 0;
        while (!input_b_ack && t < 200) begin @(negedge in_clk); t++; end
        if (t >= 200) begin chk(1'b0, "b_ack_timeout", 32'(t), 32'd200); input_b_stb = 1'b0; return; end
        expq.push_back('{z: model(a, b), at: cyc + 1 + W + 2});
        @(negedge in_clk);
        input_b_stb = 1'b0;
        if (abort) begin
            repeat (6) @(negedge in_clk);
            #2 in_reset = 1'b0;
            #1;
            chk({input_a_ack, input_b_ack, output_z_stb} == 3'b000, "reset_ctrl_zero",
                {29'b0, input_a_ack, input_b_ack, output_z_stb}, 32'd0);
            chk(output_z == '0, "reset_z_zero", 32'(output_z), 32'd0);
            expq.delete();
            repeat (2) @(negedge in_clk);
            in_reset = 1'b1;
            @(negedge in_clk);
            chk(input_a_ack, "a_ack_after_reset", 32'(input_a_ack), 32'd1);
            return;
        end
        t = 0;
        while (!output_z_stb && t < 200) begin
            if (noise) {input_a_stb, input_b_stb, output_z_ack} = 3'($urandom);
            @(negedge in_clk);
            t++;
        end
        input_a_stb = 1'b0;
        input_b_stb = 1'b0;
        output_z_ack = 1'b0;
        if (t >= 200) begin chk(1'b0, "z_stb_timeout", 32'(t), 32'd200); return; end
        repeat (hold) @(negedge in_clk);
        output_z_ack = 1'b1;
        @(negedge in_clk);
        output_z_ack = 1'b0;
    endtask

    initial begin : drv
        chk(model(16'h0180, 16'h0200) == 16'h0300, "model_1p5x2", 32'(model(16'h0180, 16'h0200)), 32'h0300);
        chk(model(16'hFF00, 16'h0080) == 16'hFF80, "model_m1x0p5", 32'(model(16'hFF00, 16'h0080)), 32'hFF80);
        chk(model(16'hFFFF, 16'h0080) == 16'h0000, "model_trunc0", 32'(model(16'hFFFF, 16'h0080)), 32'h0000);
        chk(model(16'h0100, 16'h0100) == 16'h0100, "model_1x1", 32'(model(16'h0100, 16'h0100)), 32'h0100);
`ifdef STB_ACK_MULT_SAT_EN
        chk(model(16'h7F00, 16'h0200) == 16'h7FFF, "model_sat_pos", 32'(model(16'h7F00, 16'h0200)), 32'h7FFF);
        chk(model(16'h8000, 16'h0200) == 16'h8000, "model_sat_neg", 32'(model(16'h8000, 16'h0200)), 32'h8000);
`else
        chk(model(16'h7F00, 16'h0200) == 16'hFE00, "model_wrap", 32'(model(16'h7F00, 16'h0200)), 32'hFE00);
`endif

        #1;
        chk({input_a_ack, input_b_ack, output_z_stb} == 3'b000, "reset_ctrl",
            {29'b0, input_a_ack, input_b_ack, output_z_stb}, 32'd0);
        chk(output_z == '0, "reset_z", 32'(output_z), 32'd0);
        repeat (3) @(negedge in_clk);
        in_reset = 1'b1;
        chk(!input_a_ack, "a_ack_low_at_release", 32'(input_a_ack), 32'd0);
        @(negedge in_clk);
        chk(input_a_ack, "a_ack_first_edge", 32'(input_a_ack), 32'd1);

        do_op(16'h0180, 16'h0200, 2, 1'b0, 1'b0, 1'b0);
        do_op(16'hFF00, 16'h0080, 0, 1'b0, 1'b0, 1'b0);
        do_op(16'hFFFF, 16'h0080, 1, 1'b0, 1'b0, 1'b0);
        do_op(16'h7F00, 16'h0200, 0, 1'b0, 1'b0, 1'b0);
        do_op(16'h8000, 16'h0200, 0, 1'b0, 1'b0, 1'b0);
        do_op(16'h0000, 16'h1234, 0, 1'b0, 1'b0, 1'b0);
        do_op(16'hC000, 16'h0000, 0, 1'b0, 1'b0, 1'b0);
        do_op(16'h8000, 16'h8000, 0, 1'b0, 1'b0, 1'b0);
        do_op(16'h1234, 16'h0567, 50, 1'b0, 1'b0, 1'b0);
        do_op(16'h0300, 16'h0400, 0, 1'b0, 1'b0, 1'b1);
        do_op(16'h0100, 16'h0100, 1, 1'b1, 1'b0, 1'b0);

        for (int i = 0; i < 40; i++)
            do_op(W'($urandom), W'($urandom), int'($urandom_range(0, 3)), 1'b0, 1'b1, 1'b0);

        repeat (5) @(negedge in_clk);
        chk(expq.size() == 0, "queue_drained", 32'(expq.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule

// File: doc/stb_ack_fixed_multiplier.md
STB_ACK_FIXED_MULTIPLIER -- requirements
Module: stb_ack_fixed_multiplier

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, meaning the operand and result width in bits (signed two's complement).
REQ-002 The block SHALL have parameter FRAC, default 8, meaning the number of fractional bits in the Q(WIDTH-FRAC).FRAC format; the legal range is 0..WIDTH-1.
REQ-003 The block SHALL have port in_clk, input, 1 bit: the clock; all state is updated on the rising edge.
REQ-004 The block SHALL have port in_reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have ports input_a (input, WIDTH), input_a_stb (input, 1) and input_a_ack (output, 1), forming the operand-A handshake.
REQ-006 The block SHALL have ports input_b (input, WIDTH), input_b_stb (input, 1) and input_b_ack (output, 1), forming the operand-B handshake.
REQ-007 The block SHALL have ports output_z (output, WIDTH), output_z_stb (output, 1) and output_z_ack (input, 1), forming the result handshake.

Function
REQ-008 The FSM SHALL have five states: GET_A, GET_B, MULT, NORM and PUT_Z; the state after reset SHALL be GET_A.
REQ-009 In GET_A, input_a_ack SHALL be 1.
- On an edge with input_a_stb=1, the block SHALL capture input_a, drive input_a_ack to 0 and move to GET_B.
REQ-010 In GET_B, input_b_ack SHALL be 1.
- On an edge with input_b_stb=1, the block SHALL capture input_b, drive input_b_ack to 0, load the multiplier and move to MULT.
REQ-011 In MULT, the block SHALL perform an unsigned radix-2 shift-add of |A| x |B|.
- One bit per cycle, exactly WIDTH cycles, then move to NORM.
- Magnitudes SHALL be WIDTH-bit unsigned, so |-2^(WIDTH-1)| = 2^(WIDTH-1) is exact.
REQ-012 In NORM (1 cycle), the block SHALL:
- Shift the 2*WIDTH-bit magnitude product right by FRAC (truncation toward zero).
- Apply the sign A[WIDTH-1] XOR B[WIDTH-1].
- Resolve overflow per REQ-021.
- Register the result on output_z, set output_z_stb=1 and move to PUT_Z.
REQ-013 Latency: if the B handshake occurs on edge k, output_z_stb SHALL first be high after edge k+WIDTH+2.
REQ-014 In PUT_Z, output_z and output_z_stb SHALL be held stable until an edge with output_z_ack=1.
- On that edge, output_z_stb SHALL go to 0 and the FSM SHALL return to GET_A.
- output_z SHALL retain its last value.
REQ-015 Stimulus outside the states that accept it SHALL be ignored:
- input_a_stb outside GET_A.
- input_b_stb outside GET_B.
- output_z_ack outside PUT_Z.
REQ-016 If input_a_stb and input_b_stb are both 1 in GET_A, only A SHALL be accepted that edge; B SHALL be accepted at the earliest on the following edge.
REQ-017 At most one of input_a_ack, input_b_ack and output_z_stb SHALL be 1 in any cycle.
REQ-018 Zero operands SHALL produce output_z = 0 with no negative zero; they SHALL take the same latency as any other operands (no early exit).

Reset
REQ-019 Assertion of in_reset SHALL, asynchronously and at any state (including mid-MULT or PUT_Z):
- Force the FSM to GET_A.
- Clear output_z, output_z_stb and input_b_ack to 0.
- Clear the operand, accumulator and counter registers.
- Discard any in-flight operation.
REQ-020 input_a_ack SHALL be 1 from the first rising edge after in_reset deasserts; it SHALL be 0 while in_reset is asserted.

Configuration
REQ-021 Saturation SHALL be controlled by macro STB_ACK_MULT_SAT_EN.
- Defined: a NORM result above 2^(WIDTH-1)-1 SHALL clamp to 2^(WIDTH-1)-1, and one below -2^(WIDTH-1) SHALL clamp to -2^(WIDTH-1).
- Undefined: output_z SHALL be the low WIDTH bits of the signed shifted product (wrap), and the saturation logic SHALL be absent.

Structure
REQ-022 Package stb_ack_mult_pkg SHALL hold:
- The state encoding constants (GET_A=3'd0, GET_B=3'd1, MULT=3'd2, NORM=3'd3, PUT_Z=3'd4).
- The defaults WIDTH=16 and FRAC=8.
REQ-023 Sub-module shift_add_core SHALL implement the WIDTH-cycle unsigned shift-add datapath (start/busy/done, 2*WIDTH-bit product).
- The FSM, sign handling, normalisation and saturation SHALL stay in the top.

Verification (WIDTH=16, FRAC=8)
REQ-024 A=0x0180, B=0x0200 (1.5 x 2.0) -> output_z=0x0300, output_z_stb high exactly 18 edges after the B handshake.
REQ-025 A=0xFF00, B=0x0080 (-1.0 x 0.5) -> 0xFF80; A=0xFFFF, B=0x0080 -> 0x0000 (truncation toward zero).
REQ-026 A=0x7F00, B=0x0200 -> 0x7FFF with STB_ACK_MULT_SAT_EN; 0xFE00 without. A=0x8000, B=0x0200 -> 0x8000 with the macro defined.
REQ-027 Hold output_z_ack=0 for 50 cycles in PUT_Z -> output_z and output_z_stb stable throughout; one ack cycle -> stb low next edge and input_a_ack high.
REQ-028 Assert in_reset during cycle 7 of MULT -> all outputs 0 immediately; after release, a new 0x0100 x 0x0100 -> 0x0100; input_a_stb and input_b_stb both high in GET_A -> A accepted first.
